// File: rtl/uart_seq_pkg.sv
// Shared types and helpers for the UART message sequencer.
//   state_t  : sequencer FSM states
//   byte_t   : default-width data byte
//   level_w  : bit width needed to hold a FIFO occupancy of 0..depth
package uart_seq_pkg;

  localparam int DEF_DATA_W = 8;

  typedef logic [DEF_DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BANNER = 2'd1,
    ECHO   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_msg_sequencer_fifo.sv
// Synchronous FIFO used to buffer echo bytes.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/level)
//   push/wdata : write request and data; ignored when full unless popping
//   pop        : remove head; ignored when empty
//   head       : current head entry (valid while !empty)
//   full/empty : occupancy flags
//   level      : exact occupancy 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo
  import uart_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         head,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A write into a full FIFO is safe when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// UART transmit-side sequencer: sends a fixed banner every PERIOD_CYC cycles
// and echoes received bytes through a FIFO so echoes arriving during a
// banner are buffered rather than lost.
//   CLK_I, RST_N_I      : clock, asynchronous active-low reset
//   RX_DATA_I/VALID_I   : byte strobe from uart_rx
//   TX_DATA_O/VALID_O   : byte to uart_tx, held stable until TX_READY_I
//   BANNER_EN_I         : enable periodic banner
//   ECHO_EN_I           : enable echo capture and drain
//   OVERFLOW_O          : sticky, an echo byte was dropped
//   BANNER_DONE_O       : one-cycle pulse on acceptance of the last banner byte
//   FIFO_LEVEL_O        : echo FIFO occupancy
// MSG_LEN and PERIOD_CYC must both be at least 2.
module uart_msg_sequencer
  import uart_seq_pkg::*;
#(
  parameter int                         DATA_W     = 8,
  parameter int                         MSG_LEN    = 6,
  parameter logic [MSG_LEN*DATA_W-1:0]  MSG        = {"Egor", 16'h0d0a},
  parameter int                         PERIOD_CYC = 27_000_000,
  parameter int                         FIFO_DEPTH = 16
) (
  input  logic                           CLK_I,
  input  logic                           RST_N_I,
  input  logic [DATA_W-1:0]              RX_DATA_I,
  input  logic                           RX_VALID_I,
  output logic [DATA_W-1:0]              TX_DATA_O,
  output logic                           TX_VALID_O,
  input  logic                           TX_READY_I,
  input  logic                           BANNER_EN_I,
  input  logic                           ECHO_EN_I,
  output logic                           OVERFLOW_O,
  output logic                           BANNER_DONE_O,
  output logic [level_w(FIFO_DEPTH)-1:0] FIFO_LEVEL_O
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam int CNT_W = $clog2(PERIOD_CYC);
  localparam int LW    = level_w(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              xfer, pop, push;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;

  // Byte 0 of the banner sits in the most-significant position of MSG.
  function automatic logic [DATA_W-1:0] msg_byte(input logic [IDX_W-1:0] i);
    return MSG[(MSG_LEN-1-int'(i))*DATA_W +: DATA_W];
  endfunction

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_I),
    .rst_n (RST_N_I),
    .push  (push),
    .pop   (pop),
    .wdata (RX_DATA_I),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Valid and data derive only from registered state, so they stay put
  // until the handshake moves the state, index or FIFO head.
  assign TX_VALID_O = (state_q == BANNER) || (state_q == ECHO);
  assign xfer       = TX_VALID_O & TX_READY_I;
  // The byte being shown is popped on its transfer even if ECHO_EN_I has
  // since dropped, so an in-flight echo always completes.
  assign pop        = (state_q == ECHO) & xfer;
  assign push       = RX_VALID_I & ECHO_EN_I & (~fifo_full | pop);

  always_comb begin
    TX_DATA_O = '0;
    case (state_q)
      BANNER:  TX_DATA_O = msg_byte(idx_q);
      ECHO:    TX_DATA_O = fifo_head;
      default: TX_DATA_O = '0;
    endcase
  end

  assign OVERFLOW_O    = ovf_q;
  assign BANNER_DONE_O = done_q;
  assign FIFO_LEVEL_O  = fifo_level;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (RX_VALID_I & ECHO_EN_I & fifo_full & ~pop) ovf_d = 1'b1;

    // Period timer: frozen during a banner, cleared while banners are off.
    if (!BANNER_EN_I) begin
      cnt_d = '0;
    end else if (state_q != BANNER) begin
      if (cnt_q != CNT_W'(PERIOD_CYC-1)) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(PERIOD_CYC-1)) pend_d = 1'b1;
    end

    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (pend_q & BANNER_EN_I)          state_d = BANNER;
        else if (~fifo_empty & ECHO_EN_I)  state_d = ECHO;
      end
      BANNER: begin
        if (xfer) begin
          if (idx_q == IDX_W'(MSG_LEN-1)) begin
            idx_d   = '0;
            pend_d  = 1'b0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = (~fifo_empty & ECHO_EN_I) ? ECHO : WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ECHO: begin
        if (xfer) begin
          // A same-cycle push keeps the FIFO non-empty after this pop.
          if (pend_q & BANNER_EN_I)
            state_d = BANNER;
          else if (((fifo_level > LW'(1)) | push) & ECHO_EN_I)
            state_d = ECHO;
          else
            state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed self-checking bench for uart_msg_sequencer
// (PERIOD_CYC=200, FIFO_DEPTH=4, default banner "Egor\r\n").
module tb_uart_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       banner_en;
  logic       echo_en;
  logic       ovf;
  logic       done;
  logic [2:0] level;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  logic [7:0] got_data[$];
  int         got_edge[$];

  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  logic [7:0] msg_exp [6] = '{8'h45, 8'h67, 8'h6F, 8'h72, 8'h0D, 8'h0A};

  uart_msg_sequencer #(
    .DATA_W     (8),
    .MSG_LEN    (6),
    .MSG        ({"Egor", 16'h0d0a}),
    .PERIOD_CYC (200),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_I         (clk),
    .RST_N_I       (rst_n),
    .RX_DATA_I     (rx_data),
    .RX_VALID_I    (rx_valid),
    .TX_DATA_O     (tx_data),
    .TX_VALID_O    (tx_valid),
    .TX_READY_I    (tx_ready),
    .BANNER_EN_I   (banner_en),
    .ECHO_EN_I     (echo_en),
    .OVERFLOW_O    (ovf),
    .BANNER_DONE_O (done),
    .FIFO_LEVEL_O  (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Mid-cycle monitor: logs transfers (with the edge they happen on),
  // counts done pulses and checks that a stalled byte is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_vld", int'(tx_valid), 1);
        check("hold_data", int'(tx_data), int'(stall_data));
      end
      if (tx_valid && tx_ready) begin
        got_data.push_back(tx_data);
        got_edge.push_back(edge_cnt + 1);
      end
      if (done) done_cnt++;
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n, input int bound, input string tag);
    int k = 0;
    while (got_data.size() < n && k < bound) begin
      cyc(1);
      k++;
    end
    check(tag, int'(got_data.size() >= n), 1);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int k = 0;
    while (!tx_valid && k < bound) begin
      cyc(1);
      k++;
    end
    check(tag, int'(tx_valid), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},   int'(tx_valid), 0);
    check({tag, "_data"},  int'(tx_data), 0);
    check({tag, "_ovf"},   int'(ovf), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_level"}, int'(level), 0);
  endtask

  task automatic check_banner(input int base, input string tag);
    for (int i = 0; i < 6; i++)
      if (base + i < got_data.size())
        check($sformatf("%s_b%0d", tag, i), int'(got_data[base+i]), int'(msg_exp[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int eb;
    rst_n = 1'b0; tx_ready = 1'b1; banner_en = 1'b1; echo_en = 1'b1;
    rx_valid = 1'b0; rx_data = '0;

    // 1: reset values, first-byte latency, back-to-back banner, period
    cyc(2);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    cyc(1);
    check("t1_idle_vld", int'(tx_valid), 0);
    cyc(1);
    check("t1_first_vld", int'(tx_valid), 1);
    check("t1_first_byte", int'(tx_data), 8'h45);
    wait_xfers(6, 20, "t1_xfers");
    check_banner(0, "t1");
    for (int i = 1; i < 6; i++)
      if (i < got_edge.size())
        check($sformatf("t1_gap%0d", i), got_edge[i] - got_edge[i-1], 1);
    cyc(2);
    check("t1_done_cnt", done_cnt, 1);
    tx_ready = 1'b0;
    wait_valid(300, "t1_next_banner");
    if (got_edge.size() >= 6)
      check("t1_period", edge_cnt - got_edge[5], 200);

    // 2: ready one cycle in three; bytes held across stalls, order intact
    begin
      int i = 0;
      while (got_data.size() < 12 && i < 60) begin
        tx_ready = ((i % 3) == 2);
        cyc(1);
        i++;
      end
    end
    check("t2_xfers", int'(got_data.size() >= 12), 1);
    check_banner(6, "t2");
    cyc(2);
    check("t2_done_cnt", done_cnt, 2);

    // 3: echo in WAIT, level 1..3 then drain to 0
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h31 + 8'(i);
      cyc(1);
      check($sformatf("t3_level%0d", i + 1), int'(level), i + 1);
    end
    rx_valid = 1'b0;
    check("t3_head_vld", int'(tx_valid), 1);
    check("t3_head", int'(tx_data), 8'h31);
    tx_ready = 1'b1;
    wait_xfers(15, 20, "t3_xfers");
    for (int i = 0; i < 3; i++)
      if (12 + i < got_data.size())
        check($sformatf("t3_echo%0d", i), int'(got_data[12+i]), 8'h31 + i);
    cyc(1);
    check("t3_level_end", int'(level), 0);
    check("t3_ovf", int'(ovf), 0);

    // 4: overflow while the banner is stalled
    rst_n = 1'b0; tx_ready = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    base = got_data.size();
    wait_valid(10, "t4_banner_vld");
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h41 + 8'(i);
      cyc(1);
    end
    rx_valid = 1'b0;
    check("t4_level_full", int'(level), 4);
    check("t4_ovf", int'(ovf), 1);
    check("t4_stalled_byte", int'(tx_data), 8'h45);
    tx_ready = 1'b1;
    wait_xfers(base + 10, 40, "t4_xfers");
    check_banner(base, "t4");
    for (int i = 0; i < 4; i++)
      if (base + 6 + i < got_data.size())
        check($sformatf("t4_echo%0d", i), int'(got_data[base+6+i]), 8'h41 + i);
    eb = 0;
    if (got_edge.size() >= base + 7) begin
      check("t4_no_bubble", got_edge[base+6] - got_edge[base+5], 1);
      eb = got_edge[base+5];
    end
    cyc(20);
    check("t4_lost", got_data.size(), base + 10);
    check("t4_level_end", int'(level), 0);
    check("t4_ovf_sticky", int'(ovf), 1);

    // 5: period expires while an echo byte is stalled
    tx_ready = 1'b0;
    while (edge_cnt < eb + 150) cyc(1);
    rx_valid = 1'b1; rx_data = 8'h51;
    cyc(1);
    rx_data = 8'h52;
    cyc(1);
    rx_valid = 1'b0;
    check("t5_level", int'(level), 2);
    while (edge_cnt < eb + 210) cyc(1);
    check("t5_stall_vld", int'(tx_valid), 1);
    check("t5_stall_byte", int'(tx_data), 8'h51);
    tx_ready = 1'b1;
    base = got_data.size();
    wait_xfers(base + 8, 40, "t5_xfers");
    if (base < got_data.size())
      check("t5_first_echo", int'(got_data[base]), 8'h51);
    check_banner(base + 1, "t5");
    if (base + 7 < got_data.size())
      check("t5_last_echo", int'(got_data[base+7]), 8'h52);
    cyc(1);
    check("t5_level_end", int'(level), 0);

    // 6: asynchronous reset mid-banner
    tx_ready = 1'b0;
    wait_valid(300, "t6_banner_vld");
    rx_valid = 1'b1; rx_data = 8'h77; tx_ready = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
    tx_ready = 1'b0;
    base = got_data.size();
    if (base >= 2) begin
      check("t6_pre_b0", int'(got_data[base-2]), 8'h45);
      check("t6_pre_b1", int'(got_data[base-1]), 8'h67);
    end
    check("t6_pre_vld", int'(tx_valid), 1);
    check("t6_pre_data", int'(tx_data), 8'h6F);
    check("t6_pre_level", int'(level), 1);
    check("t6_pre_ovf", int'(ovf), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    cyc(1);
    rst_n = 1'b1; tx_ready = 1'b1;
    wait_xfers(base + 6, 20, "t6_xfers");
    check_banner(base, "t6");
    cyc(20);
    check("t6_no_echo", got_data.size(), base + 6);
    check("t6_level", int'(level), 0);
    check("t6_ovf", int'(ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
